instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sits directly downstream of the program counter stage.
- Accepts one word-aligned byte address per handshake and reads four consecutive bytes over an 8-bit memory port.
- Assembles the bytes little-endian into a 32-bit instruction and presents it with its PC on a valid/ready output.
- A synchronous flush abandons any in-flight fetch after a redirect.

Parameters:
- ADDR_W, 8, width of PC and memory address; all address arithmetic is modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  fetch address from the PC stage.
- pc_valid  in  1  pc holds a new address.
- pc_ready  out  1  unit can accept an address.
- flush  in  1  discard the current fetch and any held instruction.
- mem_req  out  1  byte read request.
- mem_addr  out  ADDR_W  byte address of the current request.
- mem_ack  in  1  mem_rdata valid; the current byte completes.
- mem_rdata  in  8  read data.
- instr  out  32  assembled instruction.
- instr_pc  out  ADDR_W  address the instruction was fetched from.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  consumer accepts the instruction.
- fetch_fault  out  1  one-cycle pulse: misaligned pc rejected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, byte count=0.
  - instr=0, instr_pc=0, instr_valid=0, mem_req=0, mem_addr=0, fetch_fault=0.
  - pc_ready=1, since it is decoded from state.
  - Reset mid-fetch drops all partial data immediately.
- States: IDLE, REQ, OUT.
- pc_ready=1 only in IDLE. Accept means pc_valid & pc_ready at a rising edge.
- IDLE:
  - On accept with pc[1:0]==00: latch base=pc, clear count and assembly register, go to REQ.
  - On accept with pc[1:0]!=00: pulse fetch_fault for the next cycle, issue no memory access, stay IDLE.
- REQ:
  - mem_req=1, mem_addr=base+count (mod 2^ADDR_W).
  - Each edge with mem_ack=1 stores mem_rdata into instr bits [8*count+7:8*count] and increments count.
  - After the 4th ack (count==3), go to OUT.
  - With mem_ack=0, mem_req and mem_addr hold steady.
  - mem_req stays high across back-to-back bytes; the address changes the cycle after each ack.
- OUT:
  - instr_valid=1; instr and instr_pc=base are stable until transfer.
  - On instr_ready=1 at an edge: transfer, go to IDLE, so pc_ready=1 next cycle.
  - instr_valid never drops without instr_ready or flush.
- Latency with zero-wait memory (mem_ack tied 1):
  - accept at edge 0;
  - mem_addr = base, base+1, base+2, base+3 in cycles 1–4;
  - instr_valid high in cycle 5.
  - Throughput: one instruction per 6 cycles with instr_ready tied 1.
- flush (synchronous, highest priority):
  - From any state, next cycle state=IDLE, mem_req=0, instr_valid=0, count=0.
  - A pc_valid or mem_ack coinciding with flush is ignored. Memory must tolerate a dropped ack.
  - instr and instr_pc retain stale values; consumers qualify with instr_valid.
- Wrap-around: base=0xFC reads FC,FD,FE,FF; addressing never crosses 0xFF within a word because base is aligned.
- fetch_fault and a valid fetch are never both active.

Test Plan:
- Reset then pc=0x10, pc_valid pulse, mem_ack=1, mem bytes 11,22,33,44 → mem_addr 10,11,12,13 in cycles 1–4; instr=0x44332211, instr_pc=0x10, instr_valid in cycle 5; pc_ready=0 cycles 1–5.
- Wait states: mem_ack low for 2 cycles before each byte at pc=0x20 → mem_addr held per byte; instr_valid at cycle 13; value correct.
- Backpressure: instr_ready=0 for 5 cycles in OUT → instr/instr_pc stable, pc_ready=0; a pc_valid offered meanwhile is not accepted; it is accepted the cycle after instr_ready=1.
- Misaligned pc=0x13 → fetch_fault=1 for exactly one cycle, mem_req stays 0, pc_ready stays 1.
- Flush after 2nd byte acked at pc=0x40, with mem_ack=1 that cycle → mem_req=0 next cycle, IDLE. New pc=0x80 fetch returns only 0x80–0x83 data and instr_pc=0x80.
- Async reset asserted mid-REQ (count=2) → mem_req, instr_valid, count clear without a clock edge; after release, pc_ready=1.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the PC-side, memory-side and instruction-side handshakes of the fetch unit.
// The master view belongs to the fetch unit; the slave view belongs to its surroundings.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              pc_ready;
    logic              flush;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              fetch_fault;

    modport master (
        input  pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
        output pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_fault
    );

    modport slave (
        output pc, pc_valid, flush, mem_ack, mem_rdata, instr_ready,
        input  pc_ready, mem_req, mem_addr, instr, instr_pc, instr_valid, fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetches a 32-bit little-endian instruction as four byte reads over an 8-bit memory port.
// A synchronous flush abandons any in-flight fetch or held instruction.
module instr_fetch_unit #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [31:0]       instr_q, instr_d;
    logic              fault_q, fault_d;
    logic              accept;

    assign accept = bus.pc_valid && (state_q == IDLE);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        count_d = count_q;
        base_d  = base_q;
        instr_d = instr_q;
        fault_d = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
            count_d = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bus.pc[1:0] == 2'b00) begin
                            base_d  = bus.pc;
                            count_d = 2'd0;
                            instr_d = 32'h0;
                            state_d = REQ;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_ack) begin
                        // Byte n of the word lands in bits [8n+7:8n] (little-endian).
                        instr_d[{count_q, 3'b000} +: 8] = bus.mem_rdata;
                        count_d = count_q + 2'd1;
                        if (count_q == 2'd3) begin
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.instr_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 2'd0;
            base_q  <= '0;
            instr_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            base_q  <= base_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    // The base is word-aligned, so adding the byte index never carries out of the word.
    assign bus.mem_addr    = base_q + {{(ADDR_W-2){1'b0}}, count_q};
    assign bus.mem_req     = (state_q == REQ);
    assign bus.pc_ready    = (state_q == IDLE);
    assign bus.instr_valid = (state_q == OUT);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = base_q;
    assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a byte-array memory model.
// Each task walks the unit cycle by cycle and compares outputs to hand-computed values.
module tb_instr_fetch_unit;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_fail   = 0;

    instr_fetch_unit_if #(.ADDR_W(8)) bus ();

    instr_fetch_unit #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Outputs are sampled 1 time unit after the rising edge; inputs driven there act on the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packed status: {mem_req, pc_ready, instr_valid, fetch_fault}
    function automatic logic [3:0] flags();
        return {bus.mem_req, bus.pc_ready, bus.instr_valid, bus.fetch_fault};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.pc = 8'h00; bus.pc_valid = 1'b0; bus.flush = 1'b0;
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
        #12;
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL reset_flags: got %b expected %b", flags(), 4'b0100);
        end
        n_checks++;
        if ({bus.instr, bus.instr_pc, bus.mem_addr} !== 48'h0) begin
            n_fail++; $display("FAIL reset_data: got %h expected %h", {bus.instr, bus.instr_pc, bus.mem_addr}, 48'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL post_reset_flags: got %b expected %b", flags(), 4'b0100);
        end
    endtask

    task automatic test_basic_fetch();
        logic [7:0] exp_a;
        bus.pc = 8'h10; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1; bus.instr_ready = 1'b0;
        step();
        bus.pc_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp_a = 8'h10 + 8'(c - 1);
            n_checks++;
            if (flags() !== 4'b1000 || bus.mem_addr !== exp_a) begin
                n_fail++; $display("FAIL basic_req c%0d: got flags %b addr %h expected flags 1000 addr %h", c, flags(), bus.mem_addr, exp_a);
            end
            step();
        end
        n_checks++;
        if (flags() !== 4'b0010 || bus.instr !== 32'h44332211 || bus.instr_pc !== 8'h10) begin
            n_fail++; $display("FAIL basic_out: got flags %b instr %h pc %h expected 0010 44332211 10", flags(), bus.instr, bus.instr_pc);
        end
        bus.instr_ready = 1'b1; bus.mem_ack = 1'b0;
        step();
        bus.instr_ready = 1'b0;
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL basic_return_idle: got %b expected %b", flags(), 4'b0100);
        end
    endtask

    task automatic test_wait_states();
        logic [7:0] exp_a;
        bus.pc = 8'h20; bus.pc_valid = 1'b1; bus.mem_ack = 1'b0;
        step();
        bus.pc_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            bus.mem_ack = (c % 3 == 0);
            exp_a = 8'h20 + 8'((c - 1) / 3);
            n_checks++;
            if (flags() !== 4'b1000 || bus.mem_addr !== exp_a) begin
                n_fail++; $display("FAIL wait_req c%0d: got flags %b addr %h expected flags 1000 addr %h", c, flags(), bus.mem_addr, exp_a);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (flags() !== 4'b0010 || bus.instr !== 32'hD4C3B2A1 || bus.instr_pc !== 8'h20) begin
            n_fail++; $display("FAIL wait_out: got flags %b instr %h pc %h expected 0010 d4c3b2a1 20", flags(), bus.instr, bus.instr_pc);
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_backpressure_wrap();
        logic [7:0] exp_a;
        bus.pc = 8'hFC; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            exp_a = 8'hFC + 8'(c - 1);
            n_checks++;
            if (flags() !== 4'b1000 || bus.mem_addr !== exp_a) begin
                n_fail++; $display("FAIL wrap_req c%0d: got flags %b addr %h expected flags 1000 addr %h", c, flags(), bus.mem_addr, exp_a);
            end
            step();
        end
        bus.mem_ack = 1'b0;
        bus.pc = 8'h10; bus.pc_valid = 1'b1;
        for (int c = 5; c <= 10; c++) begin
            n_checks++;
            if (flags() !== 4'b0010 || bus.instr !== 32'hF3F2F1F0 || bus.instr_pc !== 8'hFC) begin
                n_fail++; $display("FAIL hold_out c%0d: got flags %b instr %h pc %h expected 0010 f3f2f1f0 fc", c, flags(), bus.instr, bus.instr_pc);
            end
            if (c == 10) bus.instr_ready = 1'b1;
            step();
        end
        bus.instr_ready = 1'b0;
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL hold_release_idle: got %b expected %b", flags(), 4'b0100);
        end
        bus.mem_ack = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if (flags() !== 4'b1000 || bus.mem_addr !== 8'h10) begin
            n_fail++; $display("FAIL hold_accept: got flags %b addr %h expected flags 1000 addr 10", flags(), bus.mem_addr);
        end
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (flags() !== 4'b0010 || bus.instr !== 32'h44332211 || bus.instr_pc !== 8'h10) begin
            n_fail++; $display("FAIL hold_next_out: got flags %b instr %h pc %h expected 0010 44332211 10", flags(), bus.instr, bus.instr_pc);
        end
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        bus.pc = 8'h13; bus.pc_valid = 1'b1; bus.mem_ack = 1'b0;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if (flags() !== 4'b0101) begin
            n_fail++; $display("FAIL misaligned_fault: got %b expected %b", flags(), 4'b0101);
        end
        step();
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL misaligned_pulse_end: got %b expected %b", flags(), 4'b0100);
        end
    endtask

    task automatic test_flush();
        bus.pc = 8'h40; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (flags() !== 4'b1000 || bus.mem_addr !== 8'h42) begin
            n_fail++; $display("FAIL flush_pre: got flags %b addr %h expected flags 1000 addr 42", flags(), bus.mem_addr);
        end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL flush_idle: got %b expected %b", flags(), 4'b0100);
        end
        bus.pc = 8'h80; bus.pc_valid = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        n_checks++;
        if (flags() !== 4'b1000 || bus.mem_addr !== 8'h80) begin
            n_fail++; $display("FAIL flush_refetch_addr: got flags %b addr %h expected flags 1000 addr 80", flags(), bus.mem_addr);
        end
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (flags() !== 4'b0010 || bus.instr !== 32'h04030201 || bus.instr_pc !== 8'h80) begin
            n_fail++; $display("FAIL flush_refetch_out: got flags %b instr %h pc %h expected 0010 04030201 80", flags(), bus.instr, bus.instr_pc);
        end
        bus.mem_ack = 1'b0; bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.pc = 8'h20; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1;
        step();
        bus.pc_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (flags() !== 4'b1000 || bus.mem_addr !== 8'h22) begin
            n_fail++; $display("FAIL areset_pre: got flags %b addr %h expected flags 1000 addr 22", flags(), bus.mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (flags() !== 4'b0100 || bus.mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL areset_clear: got flags %b addr %h expected flags 0100 addr 00", flags(), bus.mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ack = 1'b0;
        step();
        n_checks++;
        if (flags() !== 4'b0100) begin
            n_fail++; $display("FAIL areset_release: got %b expected %b", flags(), 4'b0100);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] mask;
        mask = '0;
        bus.pc = 8'h10; bus.pc_valid = 1'b1; bus.mem_ack = 1'b1; bus.instr_ready = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            mask[c-1] = bus.instr_valid;
            if (c == 17) begin
                n_checks++;
                if (bus.instr !== 32'h44332211) begin
                    n_fail++; $display("FAIL b2b_instr: got %h expected %h", bus.instr, 32'h44332211);
                end
            end
        end
        bus.pc_valid = 1'b0; bus.mem_ack = 1'b0; bus.instr_ready = 1'b0;
        n_checks++;
        if (mask !== 18'h10410) begin
            n_fail++; $display("FAIL b2b_valid_cycles: got %b expected %b", mask, 18'h10410);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
        mem[8'h20] = 8'hA1; mem[8'h21] = 8'hB2; mem[8'h22] = 8'hC3; mem[8'h23] = 8'hD4;
        mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;
        mem[8'h80] = 8'h01; mem[8'h81] = 8'h02; mem[8'h82] = 8'h03; mem[8'h83] = 8'h04;
        mem[8'hFC] = 8'hF0; mem[8'hFD] = 8'hF1; mem[8'hFE] = 8'hF2; mem[8'hFF] = 8'hF3;

        test_reset();
        test_basic_fetch();
        test_wait_states();
        test_backpressure_wrap();
        test_misaligned();
        test_flush();
        test_async_reset();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
